// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared CPU fetch constants, state encoding and helpers
package fetch_unit_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH    = 2'b00,
        WAIT_MEM = 2'b01,
        EXEC     = 2'b10
    } fetch_state_e;

    // Drop the byte offset so every PC stays word-aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_register.sv
// rtl/fetch_unit_pc_register.sv - program counter with reset value and branch/sequential select
module fetch_unit_pc_register
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RST_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic        branch_taken,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Next PC: aligned branch target or the sequential successor, only when loading.
    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = branch_taken ? align_word(target) : pc_q + 32'd4;
        end
    end

    // PC register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RST_VALUE;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem busywait handshake, instruction latch
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = fetch_unit_pkg::RESET_PC
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] TARGET,
    input  logic        STALL,
    input  logic        IMEM_BUSYWAIT,
    input  logic [31:0] IMEM_READDATA,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic [31:0] INSTRUCTION,
    output logic        INSTR_VALID
);

    fetch_state_e           state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic                   retire;

    // Next-state, instruction capture and retire decision.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        valid_d = valid_q;
        retire  = 1'b0;
        case (state_q)
            FETCH: begin
                state_d = WAIT_MEM;
            end
            WAIT_MEM: begin
                if (!IMEM_BUSYWAIT) begin
                    instr_d = IMEM_READDATA;
                    valid_d = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!STALL) begin
                    retire  = 1'b1;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = FETCH;
            end
        endcase
    end

    // State, valid flag and instruction latch; reset discards any captured word.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= FETCH;
            valid_q <= 1'b0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
        end
    end

    fetch_unit_pc_register #(
        .RST_VALUE (RESET_PC)
    ) u_pc_register (
        .clk          (CLK),
        .rst          (RESET),
        .load_en      (retire),
        .branch_taken (BRANCH_TAKEN),
        .target       (TARGET),
        .pc           (PC),
        .pc_plus4     (PC_PLUS4)
    );

    // Reset abandons the outstanding read at once, so the request is masked while RESET is high.
    assign IMEM_READ    = !RESET && ((state_q == FETCH) || (state_q == WAIT_MEM));
    assign IMEM_ADDRESS = PC;
    assign INSTRUCTION  = instr_q;
    assign INSTR_VALID  = valid_q;

endmodule
